fb_combiner: RTL and testbench

- Parametrised successor to the 4-channel feedback output stage.
- Sums N_CH gain-scaled dipole products plus a banana correction term through a pipelined adder tree.
- Sequences per-bunch output updates within a store window, drives fb_sgnl and a DAC strobe, and reports instantaneous and sticky overflow.
- Sits between the DSP product units and the DAC output pins.

---
 rtl/fb_pkg.sv | 33 +++
 rtl/fb_adder_tree.sv | 64 ++++++
 rtl/fb_combiner.sv | 142 ++++++++++++++
 tb/tb_fb_combiner.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and arithmetic helpers for the feedback combiner.
// FB_COMBINER_SAT_EN selects saturation instead of wrap on range overflow.
package fb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DRIVE = 2'd2,
    HOLD  = 2'd3
  } fb_state_e;

  // One guard bit per doubling of the term count keeps the tree overflow-free.
  function automatic int sum_width(input int in_w, input int corr_w, input int n_ch);
    return ((in_w > corr_w) ? in_w : corr_w) + $clog2(n_ch + 1);
  endfunction

  function automatic logic out_ovf(input logic signed [31:0] v, input int w);
    return (v > ((32'sd1 <<< (w - 1)) - 32'sd1)) || (v < -(32'sd1 <<< (w - 1)));
  endfunction

  // Caller keeps the low w bits, which gives the legacy wrap when not saturating.
  function automatic logic signed [31:0] out_fit(input logic signed [31:0] v, input int w);
`ifdef FB_COMBINER_SAT_EN
    if (out_ovf(v, w)) begin
      return (v < 0) ? -(32'sd1 <<< (w - 1)) : ((32'sd1 <<< (w - 1)) - 32'sd1);
    end
    return v;
`else
    return v;
`endif
  endfunction

endpackage

// File: rtl/fb_adder_tree.sv
// Pipelined signed adder tree: one register level per pairwise reduction,
// valid and a sideband flag travel with the data; flush drops in-flight valids.
module fb_adder_tree #(
  parameter int N_IN = 5,
  parameter int W    = 19
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  vld_in,
  input  logic                  aux_in,
  input  logic [N_IN*W-1:0]     din,
  output logic                  vld_out,
  output logic                  aux_out,
  output logic signed [W-1:0]   sum_out
);

  localparam int D = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int N = 1 << D;

  logic [N*W-1:0]      din_pad;
  logic signed [W-1:0] tree_d [D][N];
  logic signed [W-1:0] tree_q [D][N];
  logic [D-1:0]        vld_d, vld_q;
  logic [D-1:0]        aux_d, aux_q;

  // Missing leaves are zero, so odd term counts reduce without special cases.
  assign din_pad = (N*W)'(din);

  always_comb begin
    tree_d = '{default: '0};
    for (int j = 0; j < N / 2; j++) begin
      tree_d[0][j] = $signed(din_pad[(2*j)*W +: W]) + $signed(din_pad[(2*j+1)*W +: W]);
    end
    for (int k = 1; k < D; k++) begin
      for (int j = 0; j < N / 2; j++) begin
        tree_d[k][j] = tree_q[k-1][2*j] + tree_q[k-1][2*j+1];
      end
    end
    vld_d[0] = vld_in & ~flush;
    aux_d[0] = aux_in & ~flush;
    for (int k = 1; k < D; k++) begin
      vld_d[k] = vld_q[k-1] & ~flush;
      aux_d[k] = aux_q[k-1] & ~flush;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tree_q <= '{default: '0};
      vld_q  <= '0;
      aux_q  <= '0;
    end else begin
      tree_q <= tree_d;
      vld_q  <= vld_d;
      aux_q  <= aux_d;
    end
  end

  assign vld_out = vld_q[D-1];
  assign aux_out = aux_q[D-1];
  assign sum_out = tree_q[D-1][0];

endmodule

// File: rtl/fb_combiner.sv
// Feedback output stage: sums gain-scaled channel products plus correction and
// sequences per-bunch DAC updates in a store window. FB_COMBINER_SAT_EN: saturate.
//
//   state | meaning
//   IDLE  | store window closed, output held at zero
//   ARMED | waiting for a summed bunch from the adder tree
//   DRIVE | output just loaded, strobe issued next cycle
//   HOLD  | all bunches of this window serviced, output frozen
module fb_combiner
  import fb_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int IN_W      = 15,
  parameter int CORR_W    = 13,
  parameter int OUT_W     = 13,
  parameter int MAX_BUNCH = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   store_strb,
  input  logic [N_CH*IN_W-1:0]   ch_data,
  input  logic [N_CH-1:0]        ch_oflow,
  input  logic                   ch_valid,
  input  logic [CORR_W-1:0]      corr,
  input  logic [1:0]             no_bunches,
  input  logic                   const_en,
  input  logic [OUT_W-1:0]       const_val,
  input  logic                   oflow_clr,
  output logic [OUT_W-1:0]       fb_sgnl,
  output logic                   dac_clk,
  output logic [1:0]             bunch_cnt,
  output logic                   oflow,
  output logic                   oflow_sticky
);

  localparam int SUM_W = sum_width(IN_W, CORR_W, N_CH);
  localparam int N_IN  = N_CH + 1;

  logic [N_IN*SUM_W-1:0]   terms;
  logic                    flush;
  logic                    t_vld, t_aux, rng_ovf;
  logic signed [SUM_W-1:0] t_sum;
  logic [1:0]              nb_eff;
  logic                    sticky_set;

  fb_state_e               state_d, state_q;
  logic [OUT_W-1:0]        fb_d, fb_q;
  logic [1:0]              bunch_d, bunch_q;
  logic                    dac_d, dac_q;
  logic                    oflow_d, oflow_q;
  logic                    sticky_d, sticky_q;

  always_comb begin
    terms = '0;
    for (int i = 0; i < N_CH; i++) begin
      terms[i*SUM_W +: SUM_W] = SUM_W'($signed(ch_data[i*IN_W +: IN_W]));
    end
    terms[N_CH*SUM_W +: SUM_W] = SUM_W'($signed(corr));
  end

  assign flush = ~store_strb;

  fb_adder_tree #(
    .N_IN (N_IN),
    .W    (SUM_W)
  ) u_tree (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .vld_in  (ch_valid),
    .aux_in  (|ch_oflow),
    .din     (terms),
    .vld_out (t_vld),
    .aux_out (t_aux),
    .sum_out (t_sum)
  );

  assign nb_eff  = (int'(no_bunches) > MAX_BUNCH) ? 2'(MAX_BUNCH) : no_bunches;
  assign rng_ovf = out_ovf(32'(t_sum), OUT_W);

  always_comb begin
    state_d    = state_q;
    fb_d       = fb_q;
    bunch_d    = bunch_q;
    dac_d      = 1'b0;
    oflow_d    = oflow_q;
    sticky_set = 1'b0;
    if (!store_strb) begin
      state_d = IDLE;
      fb_d    = '0;
      bunch_d = '0;
    end else begin
      dac_d = (state_q == DRIVE);
      case (state_q)
        IDLE:  state_d = ARMED;
        ARMED: begin
          if (t_vld && (bunch_q < nb_eff)) begin
            state_d = DRIVE;
            bunch_d = bunch_q + 2'd1;
            if (const_en) begin
              fb_d = const_val;
            end else begin
              fb_d       = OUT_W'(out_fit(32'(t_sum), OUT_W));
              oflow_d    = rng_ovf | t_aux;
              sticky_set = rng_ovf | t_aux;
            end
          end
        end
        DRIVE:   state_d = (bunch_q == nb_eff) ? HOLD : ARMED;
        HOLD:    state_d = HOLD;
        default: state_d = IDLE;
      endcase
    end
    // A new overflow outranks a simultaneous clear.
    sticky_d = sticky_set | (sticky_q & ~oflow_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      fb_q     <= '0;
      bunch_q  <= '0;
      dac_q    <= 1'b0;
      oflow_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fb_q     <= fb_d;
      bunch_q  <= bunch_d;
      dac_q    <= dac_d;
      oflow_q  <= oflow_d;
      sticky_q <= sticky_d;
    end
  end

  assign fb_sgnl      = fb_q;
  assign dac_clk      = dac_q;
  assign bunch_cnt    = bunch_q;
  assign oflow        = oflow_q;
  assign oflow_sticky = sticky_q;

endmodule

// File: tb/tb_fb_combiner.sv
// Self-checking bench for fb_combiner: directed scenarios plus random traffic
// against a per-bunch reference model. Honours FB_COMBINER_SAT_EN.
module tb_fb_combiner;
  import fb_pkg::*;

  localparam int N_CH      = 4;
  localparam int IN_W      = 15;
  localparam int CORR_W    = 13;
  localparam int OUT_W     = 13;
  localparam int MAX_BUNCH = 3;
  localparam int D_LAT     = 3;
  localparam int MAXV      = 4095;
  localparam int MINV      = -4096;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 store_strb;
  logic [N_CH*IN_W-1:0] ch_data;
  logic [N_CH-1:0]      ch_oflow;
  logic                 ch_valid;
  logic [CORR_W-1:0]    corr;
  logic [1:0]           no_bunches;
  logic                 const_en;
  logic [OUT_W-1:0]     const_val;
  logic                 oflow_clr;
  logic [OUT_W-1:0]     fb_sgnl;
  logic                 dac_clk;
  logic [1:0]           bunch_cnt;
  logic                 oflow;
  logic                 oflow_sticky;

  fb_combiner #(
    .N_CH(N_CH), .IN_W(IN_W), .CORR_W(CORR_W), .OUT_W(OUT_W), .MAX_BUNCH(MAX_BUNCH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .store_strb(store_strb), .ch_data(ch_data),
    .ch_oflow(ch_oflow), .ch_valid(ch_valid), .corr(corr), .no_bunches(no_bunches),
    .const_en(const_en), .const_val(const_val), .oflow_clr(oflow_clr),
    .fb_sgnl(fb_sgnl), .dac_clk(dac_clk), .bunch_cnt(bunch_cnt), .oflow(oflow),
    .oflow_sticky(oflow_sticky)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int ch_v [N_CH];
  int corr_v;

  // reference model: window mode 0=closed 1=waiting 2=just updated 3=done
  int m_mode, m_fb, m_cnt, edge_no;
  bit m_dac, m_ofl, m_sticky;
  int q_due[$];
  int q_sum[$];
  bit q_ovf[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int fold(input int s);
`ifdef FB_COMBINER_SAT_EN
    return (s > 0) ? MAXV : MINV;
`else
    return ((s % 8192) + 8192 + 4096) % 8192 - 4096;
`endif
  endfunction

  function automatic int ref_sum();
    int s = corr_v;
    for (int i = 0; i < N_CH; i++) s += ch_v[i];
    return s;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_fb = 0; m_cnt = 0; m_dac = 0; m_ofl = 0; m_sticky = 0;
    q_due.delete(); q_sum.delete(); q_ovf.delete();
  endtask

  task automatic model_edge();
    int nb, asum;
    bit arr, aovf, rng, set_s;
    nb = (int'(no_bunches) > MAX_BUNCH) ? MAX_BUNCH : int'(no_bunches);
    arr = 0; aovf = 0; asum = 0; set_s = 0;
    if (q_due.size() > 0 && q_due[0] == edge_no) begin
      arr = 1;
      void'(q_due.pop_front());
      asum = q_sum.pop_front();
      aovf = q_ovf.pop_front();
    end
    if (store_strb && ch_valid) begin
      q_due.push_back(edge_no + D_LAT);
      q_sum.push_back(ref_sum());
      q_ovf.push_back(|ch_oflow);
    end
    if (!store_strb) begin
      q_due.delete(); q_sum.delete(); q_ovf.delete();
      m_mode = 0; m_fb = 0; m_cnt = 0; m_dac = 0;
    end else begin
      m_dac = (m_mode == 2);
      case (m_mode)
        0: m_mode = 1;
        1: if (arr && m_cnt < nb) begin
             m_cnt++;
             m_mode = 2;
             if (const_en) m_fb = int'($signed(const_val));
             else begin
               rng   = (asum > MAXV) || (asum < MINV);
               m_fb  = rng ? fold(asum) : asum;
               m_ofl = rng || aovf;
               set_s = m_ofl;
             end
           end
        2: m_mode = (m_cnt == nb) ? 3 : 1;
        default: ;
      endcase
    end
    m_sticky = set_s || (m_sticky && !oflow_clr);
    edge_no++;
  endtask

  task automatic compare_all();
    chk("fb", int'($signed(fb_sgnl)), m_fb);
    chk("dac", int'(dac_clk), int'(m_dac));
    chk("cnt", int'(bunch_cnt), m_cnt);
    chk("oflow", int'(oflow), int'(m_ofl));
    chk("sticky", int'(oflow_sticky), int'(m_sticky));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive_ch();
    for (int i = 0; i < N_CH; i++) ch_data[i*IN_W +: IN_W] = ch_v[i][IN_W-1:0];
    corr = corr_v[CORR_W-1:0];
  endtask

  task automatic pulse(input int a, input int b, input int c, input int d,
                       input int cr, input logic [N_CH-1:0] of);
    ch_v[0] = a; ch_v[1] = b; ch_v[2] = c; ch_v[3] = d; corr_v = cr;
    drive_ch();
    ch_oflow = of;
    ch_valid = 1'b1;
    step();
    ch_valid = 1'b0;
    ch_oflow = '0;
  endtask

  task automatic new_window(input int nb);
    store_strb = 1'b0;
    step();
    store_strb = 1'b1;
    no_bunches = 2'(nb);
    step();
  endtask

  int seen;

  initial begin
    rst_n = 1'b0; store_strb = 1'b0; ch_data = '0; ch_oflow = '0; ch_valid = 1'b0;
    corr = '0; no_bunches = '0; const_en = 1'b0; const_val = '0; oflow_clr = 1'b0;
    for (int i = 0; i < N_CH; i++) ch_v[i] = 0;
    corr_v = 0; edge_no = 0;
    model_reset();
    #12;
    chk("rst_fb", int'(fb_sgnl), 0);
    chk("rst_dac", int'(dac_clk), 0);
    chk("rst_cnt", int'(bunch_cnt), 0);
    chk("rst_oflow", int'(oflow), 0);
    chk("rst_sticky", int'(oflow_sticky), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // two bunches in one window, then a third that must be ignored
    store_strb = 1'b1; no_bunches = 2'd2;
    step();
    pulse(100, 200, -50, 25, -5, '0);
    step(); step(); step();
    chk("s1_fb1", int'($signed(fb_sgnl)), 270);
    chk("s1_dac_early", int'(dac_clk), 0);
    step();
    chk("s1_dac1", int'(dac_clk), 1);
    for (int i = 0; i < 15; i++) step();
    pulse(100, 200, -50, 25, -5, '0);
    step(); step(); step();
    chk("s1_fb2", int'($signed(fb_sgnl)), 270);
    step();
    chk("s1_dac2", int'(dac_clk), 1);
    step();
    chk("s1_cnt", int'(bunch_cnt), 2);
    chk("s1_hold", int'(dut.state_q), int'(HOLD));
    pulse(100, 200, -50, 25, -5, '0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin step(); seen |= int'(dac_clk); end
    chk("s1_no_third_dac", seen, 0);

    // out-of-range sum
    new_window(1);
    pulse(4000, 4000, 0, 0, 0, '0);
    step(); step(); step();
`ifdef FB_COMBINER_SAT_EN
    chk("s2_fb_sat", int'($signed(fb_sgnl)), 4095);
`else
    chk("s2_fb_wrap", int'($signed(fb_sgnl)), -192);
`endif
    chk("s2_oflow", int'(oflow), 1);
    chk("s2_sticky", int'(oflow_sticky), 1);

    // constant output leaves oflow alone
    new_window(2);
    const_en = 1'b1; const_val = OUT_W'(-1234);
    pulse(100, 200, -50, 25, -5, '0);
    step(); step(); step();
    chk("s3_fb1", int'($signed(fb_sgnl)), -1234);
    chk("s3_oflow1", int'(oflow), 1);
    for (int i = 0; i < 6; i++) step();
    pulse(100, 200, -50, 25, -5, '0);
    step(); step(); step();
    chk("s3_fb2", int'($signed(fb_sgnl)), -1234);
    chk("s3_oflow2", int'(oflow), 1);
    const_en = 1'b0;

    // store window closed with a bunch in flight
    new_window(2);
    pulse(100, 200, -50, 25, -5, '0);
    for (int i = 0; i < 6; i++) step();
    chk("s4_cnt_pre", int'(bunch_cnt), 1);
    pulse(1, 2, 3, 4, 0, '0);
    step();
    store_strb = 1'b0;
    step();
    chk("s4_fb_zero", int'($signed(fb_sgnl)), 0);
    chk("s4_cnt_zero", int'(bunch_cnt), 0);
    store_strb = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin step(); seen |= int'(dac_clk); end
    chk("s4_no_dac", seen, 0);

    // channel overflow flag and set-beats-clear on the sticky bit
    oflow_clr = 1'b1;
    step();
    oflow_clr = 1'b0;
    chk("s5_sticky_clr", int'(oflow_sticky), 0);
    new_window(2);
    pulse(10, 20, 30, 40, 0, 4'b0100);
    step(); step(); step();
    chk("s5_oflow_ch", int'(oflow), 1);
    chk("s5_sticky_set", int'(oflow_sticky), 1);
    oflow_clr = 1'b1;
    pulse(10, 20, 30, 40, 0, 4'b0100);
    chk("s5_sticky_cleared", int'(oflow_sticky), 0);
    step(); step(); step();
    oflow_clr = 1'b0;
    chk("s5_set_wins", int'(oflow_sticky), 1);

    // asynchronous reset while driving
    new_window(2);
    pulse(100, 200, -50, 25, -5, '0);
    step(); step(); step();
    chk("s6_in_drive", int'(dut.state_q), int'(DRIVE));
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("s6_fb", int'(fb_sgnl), 0);
    chk("s6_dac", int'(dac_clk), 0);
    chk("s6_cnt", int'(bunch_cnt), 0);
    chk("s6_oflow", int'(oflow), 0);
    chk("s6_sticky", int'(oflow_sticky), 0);
    #2;
    rst_n = 1'b1;
    step();
    chk("s6_armed", int'(dut.state_q), int'(ARMED));

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      if (store_strb) begin
        if ($urandom_range(0, 99) == 0) store_strb = 1'b0;
      end else if ($urandom_range(0, 4) == 0) begin
        store_strb = 1'b1;
      end
      if ($urandom_range(0, 49) == 0) no_bunches = 2'($urandom_range(0, 3));
      ch_valid = ($urandom_range(0, 3) == 0);
      if (ch_valid) begin
        if ($urandom_range(0, 1) == 0) begin
          for (int i = 0; i < N_CH; i++) ch_v[i] = int'($urandom_range(0, 2000)) - 1000;
          corr_v = int'($urandom_range(0, 400)) - 200;
        end else begin
          for (int i = 0; i < N_CH; i++) ch_v[i] = int'($urandom_range(0, 32767)) - 16384;
          corr_v = int'($urandom_range(0, 8191)) - 4096;
        end
        drive_ch();
        ch_oflow = ($urandom_range(0, 9) == 0) ? N_CH'($urandom) : '0;
      end else begin
        ch_oflow = '0;
      end
      const_en  = ($urandom_range(0, 4) == 0);
      const_val = OUT_W'($urandom);
      oflow_clr = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
